ucsbece154a_dmem_responder: RTL and testbench
=============================================

// Module: ucsbece154a_dmem_responder
// PURPOSE
//  Responder end of the processor data-memory interface.
//  Accepts one load/store request at a time over a valid/ready handshake.
//  Services the request from an internal word array after a fixed LATENCY.
//  Returns a response (read data or store ack) over a second valid/ready handshake.
//  Lets the core be exercised against a multi-cycle memory instead of a zero-wait one.
// PARAMETERS
//  DEPTH    64  number of 32-bit words in the array (power of 2, >=2); ADDR_W=$clog2(DEPTH)
//  LATENCY  2   cycles from request-accept edge to resp_valid_o high (>=1)
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  req_valid_i    in   1   request present
//  req_ready_o    out  1   responder can accept a request
//  req_we_i       in   1   1=store, 0=load
//  req_addr_i     in   32  byte address
//  req_wdata_i    in   32  store data
//  resp_valid_o   out  1   response present
//  resp_ready_i   in   1   requester takes the response
//  resp_rdata_o   out  32  load data; 0 for stores
//  resp_err_o     out  1   error response (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0, async):
//   - state=IDLE, cnt=0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0
//   - array contents not reset; in-flight request discarded, store not committed
//  FSM:
//   - IDLE: req_ready_o=1. On req_valid_i&req_ready_o latch we/addr/wdata, load cnt=LATENCY-1
//     -> RESP if LATENCY==1, else -> WAIT
//   - WAIT: req_ready_o=0; cnt decrements each cycle; on cnt==1 -> RESP
//   - RESP: req_ready_o=0; resp_valid_o=1; rdata/err held stable
//     -> IDLE on resp_ready_i (handshake cycle)
//  Access timing:
//   - store commits and load reads on the clock edge that enters RESP
//   - resp_valid_o rises exactly LATENCY cycles after the accept edge
//  Handshake rules:
//   - one outstanding request
//   - req inputs are ignored outside IDLE
//   - a request presented in the RESP handshake cycle is accepted no earlier than the next cycle (IDLE)
//   - peak throughput: 1 request per LATENCY+1 cycles
//  Arithmetic/width:
//   - word index = req_addr_i[ADDR_W+1:2]
//   - cnt width = $clog2(LATENCY+1)
//  Boundaries:
//   - resp_ready_i held 0: stays in RESP indefinitely, outputs stable
//   - store followed by load of the same word returns the new data
// CONFIGURATION
//  UCSBECE154A_DMEM_ERR_EN defined:
//   - misaligned requests (addr[1:0]!=0) and out-of-range requests (addr >= DEPTH*4) are error requests
//   - error requests: no array access, resp_rdata_o=0, resp_err_o=1, same LATENCY and handshake as normal
//  UCSBECE154A_DMEM_ERR_EN undefined:
//   - resp_err_o tied 0
//   - addr[1:0] ignored; upper address bits ignored, so the index wraps modulo DEPTH
// STRUCTURE
//  Package ucsbece154a_mem_pkg:
//   - WORD_W=32
//   - typedef enum {IDLE,WAIT,RESP} dmem_state_t
//   - request struct (we, addr, wdata)
//  Sub-module ucsbece154a_dmem_array:
//   - DEPTH x 32 storage, synchronous write, combinational read
//  Top holds the FSM, latency counter and response registers.
// TESTING
//  1. reset=0 mid-WAIT of a store to 0x10; release; load 0x10 -> returns pre-store value; req_ready_o=1 one cycle after release
//  2. LATENCY=2: store 0xDEADBEEF@0x8, then load 0x8 -> resp_rdata_o=0xDEADBEEF, resp_valid_o exactly 2 cycles after each accept
//  3. LATENCY=1: back-to-back loads with resp_ready_i=1 -> one response every 2 cycles, req_ready_o=0 in RESP cycles
//  4. hold resp_ready_i=0 for 5 cycles in RESP -> resp_valid_o/resp_rdata_o stable; new req_valid_i ignored
//  5. ERR_EN: load 0x6 -> resp_err_o=1, rdata=0; load 0x100 with DEPTH=64 -> err=1; array unchanged
//  6. no ERR_EN: store 0xA5A5A5A5@0x100 (DEPTH=64) -> load 0x0 returns 0xA5A5A5A5, resp_err_o=0

Source files
------------

// File: rtl/ucsbece154a_mem_pkg.sv
// Shared types and address helpers for the data-memory responder.
// Imported by ucsbece154a_dmem_responder and ucsbece154a_dmem_array.
package ucsbece154a_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } dmem_req_t;

    function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    // Any bit above the word index set means the byte address is past the array.
    function automatic logic is_out_of_range(
        input logic [WORD_W-1:0] addr,
        input int                addr_w
    );
        return (addr >> (addr_w + 2)) != '0;
    endfunction

endpackage

// File: rtl/ucsbece154a_dmem_array.sv
// Word storage for the data-memory responder.
// Synchronous write, combinational read, contents are never reset.
module ucsbece154a_dmem_array
    import ucsbece154a_mem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ucsbece154a_dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed LATENCY.
// Define UCSBECE154A_DMEM_ERR_EN to flag misaligned/out-of-range requests.
module ucsbece154a_dmem_responder
    import ucsbece154a_mem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [WORD_W-1:0] req_addr_i,
    input  logic [WORD_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [WORD_W-1:0] resp_rdata_o,
    output logic              resp_err_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(LATENCY + 1);

    dmem_state_t       state;
    dmem_state_t       next_state;
    logic [CNT_W-1:0]  cnt;
    dmem_req_t         req_q;
    dmem_req_t         acc;
    logic              accept;
    logic              enter_resp;
    logic              acc_err;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_idx;
    logic [WORD_W-1:0] arr_rdata;
    logic [WORD_W-1:0] rdata_q;
    logic              err_q;

    assign accept = req_valid_i && req_ready_o;

    // With LATENCY==1 the access happens on the accept edge itself,
    // so the live request is used while idle and the latched one after.
    always_comb begin
        acc = req_q;
        if (state == IDLE) begin
            acc.we    = req_we_i;
            acc.addr  = req_addr_i;
            acc.wdata = req_wdata_i;
        end
    end

    assign enter_resp = (accept && (LATENCY == 1))
                     || ((state == WAIT) && (cnt == CNT_W'(1)));

`ifdef UCSBECE154A_DMEM_ERR_EN
    assign acc_err = is_misaligned(acc.addr)
                  || is_out_of_range(acc.addr, ADDR_W);
`else
    logic unused_addr;
    assign acc_err     = 1'b0;
    assign unused_addr = ^{acc.addr >> (ADDR_W + 2), acc.addr[1:0]};
`endif

    assign arr_idx = acc.addr[ADDR_W+1:2];
    assign arr_we  = enter_resp && acc.we && !acc_err;

    ucsbece154a_dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (acc.wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        unique case (state)
            IDLE:    req_ready_o  = 1'b1;
            RESP:    resp_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(LATENCY - 1);
        end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= acc;
        end
    end

    // Response payload is captured once and held for the whole RESP state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= (acc.we || acc_err) ? '0 : arr_rdata;
            err_q   <= acc_err;
        end
    end

    assign resp_rdata_o = rdata_q;

`ifdef UCSBECE154A_DMEM_ERR_EN
    assign resp_err_o = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
    assign resp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ucsbece154a_dmem_responder.sv
// Directed bench: instance a uses LATENCY=2, instance b uses LATENCY=1.
// Error-response cases are selected by UCSBECE154A_DMEM_ERR_EN.
module tb_ucsbece154a_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_req_valid, a_req_ready, a_req_we;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic        a_resp_valid, a_resp_ready, a_resp_err;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic        b_resp_valid, b_resp_ready, b_resp_err;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] W0 = 32'h1234_5678;
    localparam logic [31:0] W1 = 32'h9ABC_DEF0;
    localparam logic        T_WE   [8] = '{1'b1, 1'b1, 1'b1, 1'b0,
                                           1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [31:0] T_ADDR [8] = '{32'h0, 32'h4, 32'h4, 32'h0,
                                           32'h0, 32'h4, 32'h4, 32'h0};
    localparam logic [31:0] T_WD   [8] = '{W0, W1, W1, 32'h0,
                                           32'h0, 32'h0, 32'h0, 32'h0};
    localparam logic [31:0] T_RD   [8] = '{32'h0, 32'h0, 32'h0, 32'h0,
                                           32'h0, W0, 32'h0, W1};

    always #5 clk = ~clk;

    ucsbece154a_dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (a_req_valid),
        .req_ready_o  (a_req_ready),
        .req_we_i     (a_req_we),
        .req_addr_i   (a_req_addr),
        .req_wdata_i  (a_req_wdata),
        .resp_valid_o (a_resp_valid),
        .resp_ready_i (a_resp_ready),
        .resp_rdata_o (a_resp_rdata),
        .resp_err_o   (a_resp_err)
    );

    ucsbece154a_dmem_responder #(.DEPTH(64), .LATENCY(1)) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (b_req_valid),
        .req_ready_o  (b_req_ready),
        .req_we_i     (b_req_we),
        .req_addr_i   (b_req_addr),
        .req_wdata_i  (b_req_wdata),
        .resp_valid_o (b_resp_valid),
        .resp_ready_i (b_resp_ready),
        .resp_rdata_o (b_resp_rdata),
        .resp_err_o   (b_resp_err)
    );

    // Presents a request on a and returns #1 after the edge that accepts it.
    task automatic send_a(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        logic done;
        done        = 1'b0;
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (a_req_ready) done = 1'b1;
        end
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_a accept timeout addr=%h", addr);
        end
    endtask

    // n = index of the first falling edge after accept showing resp_valid.
    task automatic wait_resp_a(output int n, output logic [31:0] rdata,
                               output logic err);
        logic done;
        done  = 1'b0;
        n     = 99;
        rdata = 32'h0;
        err   = 1'b0;
        for (int i = 1; i <= 20 && !done; i++) begin
            @(negedge clk);
            if (a_resp_valid) begin
                done  = 1'b1;
                n     = i;
                rdata = a_resp_rdata;
                err   = a_resp_err;
            end
        end
    endtask

    task automatic xact_a(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int n,
                          output logic [31:0] rdata, output logic err);
        send_a(we, addr, wdata);
        wait_resp_a(n, rdata, err);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        a_req_valid  = 1'b0;
        a_req_we     = 1'b0;
        a_req_addr   = 32'h0;
        a_req_wdata  = 32'h0;
        a_resp_ready = 1'b1;
        b_req_valid  = 1'b0;
        b_req_we     = 1'b0;
        b_req_addr   = 32'h0;
        b_req_wdata  = 32'h0;
        b_resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", a_req_ready);
        end
        checks++;
        if (a_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", a_resp_valid);
        end
        checks++;
        if (a_resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0", a_resp_rdata);
        end
        checks++;
        if (a_resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 0", a_resp_err);
        end
        checks++;
        if (b_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_b_valid got %b want 0", b_resp_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        int          n;
        logic [31:0] rd;
        logic        er;
        xact_a(1'b1, 32'h10, 32'h1111_1111, n, rd, er);
        send_a(1'b1, 32'h10, 32'h2222_2222);
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_ready got %b want 0", a_req_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got rdy=%b vld=%b want 1 0",
                     a_req_ready, a_resp_valid);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready got %b want 1", a_req_ready);
        end
        xact_a(1'b0, 32'h10, 32'h0, n, rd, er);
        checks++;
        if (rd !== 32'h1111_1111) begin
            errors++;
            $display("FAIL discarded_store got %h want 11111111", rd);
        end
    endtask

    task automatic test_store_load();
        int          n;
        logic [31:0] rd;
        logic        er;
        xact_a(1'b1, 32'h8, 32'hDEAD_BEEF, n, rd, er);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL store_latency got %0d want 2", n);
        end
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL store_resp got %h/%b want 0/0", rd, er);
        end
        xact_a(1'b0, 32'h8, 32'h0, n, rd, er);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL load_latency got %0d want 2", n);
        end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_data got %h want deadbeef", rd);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            b_req_valid = (k < 7);
            b_req_we    = T_WE[k];
            b_req_addr  = T_ADDR[k];
            b_req_wdata = T_WD[k];
            @(negedge clk);
            checks++;
            if (b_req_ready !== (k % 2 == 0)) begin
                errors++;
                $display("FAIL b2b_ready cyc=%0d got %b", k, b_req_ready);
            end
            checks++;
            if (b_resp_valid !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL b2b_valid cyc=%0d got %b", k, b_resp_valid);
            end
            if (k % 2 == 1) begin
                checks++;
                if (b_resp_rdata !== T_RD[k]) begin
                    errors++;
                    $display("FAIL b2b_rdata cyc=%0d got %h want %h",
                             k, b_resp_rdata, T_RD[k]);
                end
            end
            @(posedge clk);
            #1;
        end
        b_req_valid = 1'b0;
    endtask

    task automatic test_hold_resp();
        int          n;
        logic [31:0] rd;
        logic        er;
        a_resp_ready = 1'b0;
        send_a(1'b0, 32'h8, 32'h0);
        wait_resp_a(n, rd, er);
        checks++;
        if (n !== 2 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL hold_first got n=%0d %h want 2 deadbeef", n, rd);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            a_req_valid = 1'b1;
            a_req_we    = 1'b1;
            a_req_addr  = 32'h8;
            a_req_wdata = 32'h0BAD_F00D;
            @(negedge clk);
            checks++;
            if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL hold_stable got %b %h want 1 deadbeef",
                         a_resp_valid, a_resp_rdata);
            end
            checks++;
            if (a_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_ready got %b want 0", a_req_ready);
            end
        end
        a_req_valid  = 1'b0;
        a_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release got vld=%b rdy=%b want 0 1",
                     a_resp_valid, a_req_ready);
        end
        xact_a(1'b0, 32'h8, 32'h0, n, rd, er);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL hold_ignored_store got %h want deadbeef", rd);
        end
    endtask

`ifdef UCSBECE154A_DMEM_ERR_EN
    task automatic test_err();
        int          n;
        logic [31:0] rd;
        logic        er;
        xact_a(1'b0, 32'h6, 32'h0, n, rd, er);
        checks++;
        if (n !== 2 || er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_misaligned got n=%0d err=%b %h", n, er, rd);
        end
        xact_a(1'b0, 32'h100, 32'h0, n, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_range got err=%b %h want 1 0", er, rd);
        end
        xact_a(1'b1, 32'h108, 32'h0000_0077, n, rd, er);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL err_range_store got %b want 1", er);
        end
        xact_a(1'b1, 32'h9, 32'h0000_0099, n, rd, er);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL err_mis_store got %b want 1", er);
        end
        xact_a(1'b0, 32'h8, 32'h0, n, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL err_unchanged got %b %h want 0 deadbeef", er, rd);
        end
    endtask
`else
    task automatic test_wrap();
        int          n;
        logic [31:0] rd;
        logic        er;
        xact_a(1'b1, 32'h100, 32'hA5A5_A5A5, n, rd, er);
        checks++;
        if (n !== 2 || er !== 1'b0) begin
            errors++;
            $display("FAIL wrap_store got n=%0d err=%b want 2 0", n, er);
        end
        xact_a(1'b0, 32'h0, 32'h0, n, rd, er);
        checks++;
        if (rd !== 32'hA5A5_A5A5 || er !== 1'b0) begin
            errors++;
            $display("FAIL wrap_load got %h err=%b want a5a5a5a5 0", rd, er);
        end
        xact_a(1'b0, 32'hB, 32'h0, n, rd, er);
        checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL low_bits got %h err=%b want deadbeef 0", rd, er);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_store_load();
        test_back_to_back();
        test_hold_resp();
`ifdef UCSBECE154A_DMEM_ERR_EN
        test_err();
`else
        test_wrap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
